hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. It generates forwarding selects, and stall and flush controls, for the F/D, D/E and E/M pipeline registers. It detects load-use and branch-operand hazards. It also sequences a multi-cycle divide held in the Execute stage, freezing the front of the pipeline and inserting bubbles into Memory until the divider finishes.

## Interface
- DIV_CYCLES, 32, number of cycles the divide occupies Execute; legal range ≥2.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rsD, rtD  in  5  source register numbers in Decode.
- branchD  in  1  Decode holds a branch that compares its operands in Decode.
- jumpregD  in  1  Decode holds jr/jalr.
- rsE, rtE  in  5  source register numbers in Execute.
- writeregE  in  5  destination register of the Execute instruction.
- regwriteE, memtoregE  in  1  Execute writes a register / is a load.
- divstartE  in  1  Execute holds div/divu.
- writeregM  in  5  destination register of the Memory instruction.
- regwriteM, memtoregM  in  1  Memory writes a register / is a load.
- writeregW  in  5  destination register of the Writeback instruction.
- regwriteW  in  1  Writeback writes a register.
- forwardaD, forwardbD  out  1  Decode comparator operand select (1 = ALU result from Memory).
- forwardaE, forwardbE  out  2  ALU operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
- stallF, stallD, stallE  out  1  hold PC, F/D and D/E registers.
- flushE, flushM  out  1  clear D/E or E/M registers (bubble).
- divbusy  out  1  divide is stalling the pipeline.
- divdone  out  1  one-cycle pulse: quotient and remainder valid, HI/LO load enable.

## Operation
- Register 0 never matches in any comparison below; every match also requires the source field to be nonzero.
- forwardaE selects:
  - 10 if regwriteM and writeregM==rsE;
  - else 01 if regwriteW and writeregW==rsE;
  - else 00.
  - forwardbE uses the same rule on rtE.
- forwardaD = regwriteM and writeregM==rsD. forwardbD uses the same rule on rtD.
- lwstall = memtoregE and rtE≠0 and (rtE==rsD or rtE==rtD).
- branchstall = (branchD or jumpregD) and any of the following, for X in {rsD, rtD}:
  - regwriteE and writeregE==X;
  - memtoregM and writeregM==X.
- Divide state machine: states IDLE, BUSY, DONE; down-counter cnt of width $clog2(DIV_CYCLES).
  - IDLE: if divstartE, go to BUSY and load cnt=DIV_CYCLES-2; otherwise stay.
  - BUSY: if cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: go to IDLE unconditionally. divstartE is ignored here, because the same div is still in Execute this cycle.
- divstall = (IDLE and divstartE) or BUSY. divbusy = divstall. divdone = (state==DONE).
- Output priority:
  - If divstall: stallF=stallD=stallE=1, flushM=1, flushE=0. lwstall and branchstall are suppressed; they are re-evaluated after release because Decode is held.
  - Else if lwstall or branchstall: stallF=stallD=1, flushE=1, stallE=0, flushM=0.
  - Else: all stall and flush outputs are 0.
- A div entering Execute in the cycle after DONE starts a new sequence normally.

## Timing
- Forwarding and stall/flush outputs are combinational from inputs and current state, valid in the same cycle. Only state and cnt are registered.
- A divide in Execute stalls for exactly DIV_CYCLES cycles: cycle 0 (IDLE, divstartE) through cycle DIV_CYCLES-1.
- DONE occupies cycle DIV_CYCLES. In that cycle divdone=1, no stall is asserted, and the div advances to Memory at the end of the cycle.
- Reset values: state=IDLE, cnt=0.
- While rst=1, every output is forced to 0: all stall, flush and forwarding outputs, divbusy and divdone.
- Reset mid-divide aborts the sequence: state returns to IDLE the cycle after rst, and no divdone pulse is produced.
- Simultaneous events:
  - Load-use and branch hazards in the same cycle produce one combined stall (flushE=1).
  - A load-use hazard concurrent with divstall is deferred until DONE or later.

## Test plan
- Load-use: memtoregE=1, rtE=5, rsD=5 → stallF=stallD=flushE=1, stallE=0. Next cycle with memtoregE=0 → all 0.
- Forwarding priority: regwriteM=1, writeregM=3, regwriteW=1, writeregW=3, rsE=3 → forwardaE=10. Clear regwriteM → 01. Set rsE=0 → 00 even when writeregM=0.
- Branch hazard: branchD=1, regwriteE=1, writeregE=8, rtD=8 → stall with flushE=1. Same dependency moved to Memory (memtoregM=0, regwriteM=1, writeregM=8) → no stall, forwardbD=1.
- Divide, DIV_CYCLES=4: hold divstartE=1 → stallE=flushM=divbusy=1 for cycles 0–3, divdone=1 with no stall in cycle 4, IDLE in cycle 5. Back-to-back div in cycle 5 → a new 4-cycle stall.
- Divide with concurrent load-use (memtoregE=1, rtE==rsD) during BUSY → flushE=0 throughout BUSY, divstall outputs win.
- Reset in BUSY at cycle 2 → outputs 0 during rst, state IDLE, no divdone pulse. A subsequent divstartE starts a fresh full-length sequence.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Five-stage pipeline hazard unit. Produces the forwarding
//             selects, the load-use and branch-operand stalls, and sequences
//             a multi-cycle divide that is held in Execute.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchD,
    input  logic       jumpregD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic       regwriteE,
    input  logic       memtoregE,
    input  logic       divstartE,
    input  logic [4:0] writeregM,
    input  logic       regwriteM,
    input  logic       memtoregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteW,
    output logic       forwardaD,
    output logic       forwardbD,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushE,
    output logic       flushM,
    output logic       divbusy,
    output logic       divdone
);

    localparam int              CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       w_lwstall;
    logic       w_branchstall;
    logic       w_divstall;

    // Hazard detection; register 0 is never a real dependency
    always_comb begin
        w_lwstall = memtoregE && (rtE != 5'd0) &&
                    ((rtE == rsD) || (rtE == rtD));
        w_branchstall = (branchD || jumpregD) && (
            (regwriteE && (writeregE != 5'd0) &&
                ((writeregE == rsD) || (writeregE == rtD))) ||
            (memtoregM && (writeregM != 5'd0) &&
                ((writeregM == rsD) || (writeregM == rtD))));
        w_divstall = ((state_q == S_IDLE) && divstartE) || (state_q == S_BUSY);
    end

    // Divider sequencer next state; the div seen in DONE is the same one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (divstartE) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode: divide stall outranks data hazards; reset zeroes all
    always_comb begin
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        forwardaD = 1'b0;
        forwardbD = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        divbusy   = 1'b0;
        divdone   = 1'b0;
        if (!rst) begin
            if ((rsE != 5'd0) && regwriteM && (writeregM == rsE)) begin
                forwardaE = 2'b10;
            end else if ((rsE != 5'd0) && regwriteW && (writeregW == rsE)) begin
                forwardaE = 2'b01;
            end
            if ((rtE != 5'd0) && regwriteM && (writeregM == rtE)) begin
                forwardbE = 2'b10;
            end else if ((rtE != 5'd0) && regwriteW && (writeregW == rtE)) begin
                forwardbE = 2'b01;
            end
            forwardaD = (rsD != 5'd0) && regwriteM && (writeregM == rsD);
            forwardbD = (rtD != 5'd0) && regwriteM && (writeregM == rtD);
            divbusy   = w_divstall;
            divdone   = (state_q == S_DONE);
            if (w_divstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (w_lwstall || w_branchstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl (DIV_CYCLES = 4) with a
//             cycle-count reference model of the divide sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       branchD, jumpregD, regwriteE, memtoregE, divstartE;
    logic       regwriteM, memtoregM, regwriteW;
    logic       forwardaD, forwardbD, stallF, stallD, stallE;
    logic       flushE, flushM, divbusy, divdone;
    logic [1:0] forwardaE, forwardbE;

    int checks = 0;
    int errors = 0;
    // cycles since the current divide entered Execute; -1 = none in flight
    int div_age = -1;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpregD(jumpregD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .divstartE(divstartE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushE(flushE), .flushM(flushM),
        .divbusy(divbusy), .divdone(divdone)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_e(input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (regwriteM && writeregM == src) return 2'b10;
        if (regwriteW && writeregW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic dep(input logic [4:0] dst, input logic wr);
        return wr && dst != 0 && (dst == rsD || dst == rtD);
    endfunction

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        branchD = 0; jumpregD = 0; regwriteE = 0; memtoregE = 0; divstartE = 0;
        regwriteM = 0; memtoregM = 0; regwriteW = 0;
    endtask

    // Check every output against the model, then advance one clock
    task automatic step();
        logic dstall, ddone, hz;
        #2;
        dstall = !rst && ((div_age == -1 && divstartE) || (div_age >= 1 && div_age <= DC - 1));
        ddone  = !rst && (div_age == DC);
        hz     = !rst && !dstall &&
                 ((memtoregE && rtE != 0 && (rtE == rsD || rtE == rtD)) ||
                  ((branchD || jumpregD) &&
                   (dep(writeregE, regwriteE) || dep(writeregM, memtoregM))));
        chk("forwardaE", forwardaE, rst ? 2'b00 : fwd_e(rsE));
        chk("forwardbE", forwardbE, rst ? 2'b00 : fwd_e(rtE));
        chk("forwardaD", {1'b0, forwardaD}, {1'b0, !rst && rsD != 0 && regwriteM && writeregM == rsD});
        chk("forwardbD", {1'b0, forwardbD}, {1'b0, !rst && rtD != 0 && regwriteM && writeregM == rtD});
        chk("stallF",  {1'b0, stallF},  {1'b0, dstall || hz});
        chk("stallD",  {1'b0, stallD},  {1'b0, dstall || hz});
        chk("stallE",  {1'b0, stallE},  {1'b0, dstall});
        chk("flushE",  {1'b0, flushE},  {1'b0, hz});
        chk("flushM",  {1'b0, flushM},  {1'b0, dstall});
        chk("divbusy", {1'b0, divbusy}, {1'b0, dstall});
        chk("divdone", {1'b0, divdone}, {1'b0, ddone});
        @(posedge clk);
        if (rst)                             div_age = -1;
        else if (div_age == -1 && divstartE) div_age = 1;
        else if (div_age == DC)              div_age = -1;
        else if (div_age >= 1)               div_age++;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        step();                                  // reset state
        rst = 0;
        step();

        // Load-use, then released
        memtoregE = 1; rtE = 5; rsD = 5; step();
        chk("lw_flushE", {1'b0, flushE}, 2'b01);
        memtoregE = 0; step();

        // Forwarding priority
        clear_inputs();
        regwriteM = 1; writeregM = 3; regwriteW = 1; writeregW = 3; rsE = 3; step();
        chk("fwd_mem", forwardaE, 2'b10);
        regwriteM = 0; step();
        chk("fwd_wb", forwardaE, 2'b01);
        rsE = 0; writeregM = 0; regwriteM = 1; writeregW = 0; step();
        chk("fwd_r0", forwardaE, 2'b00);

        // Branch hazard, then dependency in Memory
        clear_inputs();
        branchD = 1; regwriteE = 1; writeregE = 8; rtD = 8; step();
        chk("br_stallD", {1'b0, stallD}, 2'b01);
        regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 8; step();
        chk("br_fwdbD", {1'b0, forwardbD}, 2'b01);

        // Divide held in Execute: two back-to-back sequences
        clear_inputs();
        divstartE = 1;
        for (int i = 0; i < 2 * (DC + 1); i++) begin
            if (i == DC) chk("div_done_c4", {1'b0, divdone}, 2'b01);
            step();
        end
        divstartE = 0; step();

        // Divide with concurrent load-use
        divstartE = 1; memtoregE = 1; rtE = 7; rsD = 7;
        for (int i = 0; i <= DC; i++) step();
        divstartE = 0; step();                   // load-use resurfaces
        clear_inputs(); step();

        // Reset in BUSY at cycle 2, then a fresh full sequence
        divstartE = 1; step(); step();
        rst = 1; step();
        rst = 0; divstartE = 0; step(); step();
        divstartE = 1;
        for (int i = 0; i <= DC; i++) step();
        divstartE = 0; step();

        // Randomized traffic on a small register window to provoke matches
        for (int n = 0; n < 400; n++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            branchD = 1'($urandom); jumpregD = ($urandom_range(0, 3) == 0);
            regwriteE = 1'($urandom); memtoregE = 1'($urandom);
            regwriteM = 1'($urandom); memtoregM = 1'($urandom);
            regwriteW = 1'($urandom);
            divstartE = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 40) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
